// File: rtl/joybus_pkg.sv
// Joybus shared definitions: bit-cell timing derived from the clock rate and TX FSM states.
package joybus_pkg;

    localparam int JB_CLK_PER_US = 25;

    // One Joybus bit cell is 4 us; short phase 1 us, long phase 3 us.
    function automatic int jb_t_bit(input int clk_per_us);
        return 4 * clk_per_us;
    endfunction

    function automatic int jb_t_short(input int clk_per_us);
        return clk_per_us;
    endfunction

    function automatic int jb_t_long(input int clk_per_us);
        return 3 * clk_per_us;
    endfunction

    localparam int JB_T_BIT   = jb_t_bit(JB_CLK_PER_US);
    localparam int JB_T_SHORT = jb_t_short(JB_CLK_PER_US);
    localparam int JB_T_LONG  = jb_t_long(JB_CLK_PER_US);

    typedef enum logic [1:0] {
        JB_IDLE = 2'd0,
        JB_LOW  = 2'd1,
        JB_HIGH = 2'd2,
        JB_STOP = 2'd3
    } jb_tx_state_e;

endpackage

// File: rtl/joybus_tx_if.sv
// Command handshake between the transaction sequencer (master) and the Joybus transmitter (slave).
interface joybus_tx_if #(
    parameter int MAX_BYTES = 3
) ();

    logic                   tx_start;
    logic [1:0]             tx_len;
    logic [8*MAX_BYTES-1:0] tx_data;
    logic                   tx_busy;
    logic                   tx_done;

    modport master (
        output tx_start,
        output tx_len,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_len,
        input  tx_data,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/joybus_tx.sv
// Joybus host transmitter: shifts a 1..MAX_BYTES command out MSB-first as open-drain
// pulse-width bit cells, then a console stop bit, and flags completion.
module joybus_tx
    import joybus_pkg::*;
#(
    parameter int CLK_PER_US = 25,
    parameter int MAX_BYTES  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    joybus_tx_if.slave  cmd_if,
    output logic        jb_tx_oe
);

    localparam int T_BIT   = jb_t_bit(CLK_PER_US);
    localparam int T_SHORT = jb_t_short(CLK_PER_US);
    localparam int T_LONG  = jb_t_long(CLK_PER_US);
    localparam int TIMER_W = $clog2(T_BIT + 1);
    localparam int DW      = 8 * MAX_BYTES;

    localparam logic [TIMER_W-1:0] TM_SHORT_LAST = TIMER_W'(T_SHORT - 1);
    localparam logic [TIMER_W-1:0] TM_LONG_LAST  = TIMER_W'(T_LONG - 1);
    localparam logic [TIMER_W-1:0] TM_BIT_LAST   = TIMER_W'(T_BIT - 1);
    localparam logic [TIMER_W-1:0] TM_SHORT      = TIMER_W'(T_SHORT);

    jb_tx_state_e         state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [DW-1:0]        shift_q, shift_d;
    logic [4:0]           bits_q, bits_d;
    logic                 oe_q, oe_d;
    logic                 done_q, done_d;

    logic [31:0]          len_ext;
    logic                 start_ok;
    logic [TIMER_W-1:0]   low_last;

    // A start is only honoured for a length the shift register can hold.
    assign len_ext  = {30'd0, cmd_if.tx_len};
    assign start_ok = cmd_if.tx_start && (cmd_if.tx_len != 2'd0) && (len_ext <= 32'(MAX_BYTES));

    // The bit on the wire is always the shift register MSB; a 1 gets the short low phase.
    assign low_last = shift_q[DW-1] ? TM_SHORT_LAST : TM_LONG_LAST;

    // Next-state logic. STOP holds one cycle past the low phase so tx_done lands on the
    // cycle the line is released while the FSM still refuses new starts.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        unique case (state_q)
            JB_IDLE: begin
                if (start_ok) begin
                    state_d = JB_LOW;
                    timer_d = '0;
                    shift_d = cmd_if.tx_data;
                    bits_d  = {cmd_if.tx_len, 3'b000};
                end
            end
            JB_LOW: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == low_last) begin
                    state_d = JB_HIGH;
                end
            end
            JB_HIGH: begin
                if (timer_q == TM_BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {shift_q[DW-2:0], 1'b0};
                    bits_d  = bits_q - 5'd1;
                    state_d = (bits_q != 5'd1) ? JB_LOW : JB_STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            JB_STOP: begin
                if (timer_q == TM_SHORT) begin
                    state_d = JB_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = JB_IDLE;
                timer_d = '0;
            end
        endcase
        // Outputs are decoded from the next state so the pad and done pulse come straight off flops.
        oe_d   = (state_d == JB_LOW) || ((state_d == JB_STOP) && (timer_d < TM_SHORT));
        done_d = (state_d == JB_STOP) && (timer_d == TM_SHORT);
    end

    // State, datapath and output registers; reset releases the line immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= JB_IDLE;
            timer_q <= '0;
            shift_q <= '0;
            bits_q  <= '0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    assign jb_tx_oe       = oe_q;
    assign cmd_if.tx_busy = (state_q != JB_IDLE);
    assign cmd_if.tx_done = done_q;

endmodule

// File: tb/tb_joybus_tx.sv
// Testbench for joybus_tx: vector table of frames plus hand sequences for restart,
// done/start overlap and mid-frame reset.
module tb_joybus_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic oe1, oe2;

    always #5 clk = ~clk;

    joybus_tx_if #(.MAX_BYTES(3)) bus1 ();
    joybus_tx_if #(.MAX_BYTES(2)) bus2 ();

    joybus_tx #(.CLK_PER_US(25), .MAX_BYTES(3)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_if   (bus1.slave),
        .jb_tx_oe (oe1)
    );

    joybus_tx #(.CLK_PER_US(25), .MAX_BYTES(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_if   (bus2.slave),
        .jb_tx_oe (oe2)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          dut;
        logic [1:0]  len;
        logic [23:0] data;
        bit          acc;
        int          done_at;
        logic [23:0] val;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic s, input logic [1:0] len, input logic [23:0] data);
        if (which == 1) begin
            bus1.tx_start = s;
            bus1.tx_len   = len;
            bus1.tx_data  = data;
        end else begin
            bus2.tx_start = s;
            bus2.tx_len   = len;
            bus2.tx_data  = data[23:8];
        end
    endtask

    // Ideal line drive at sample s (s=1 is the first cycle after the accepting edge).
    function automatic logic exp_oe(input int s, input int nbits, input logic [23:0] data);
        int b, p;
        if (s < 1 || nbits == 0) return 1'b0;
        b = (s - 1) / 100;
        p = (s - 1) % 100;
        if (b < nbits) return (p < (data[23-b] ? 25 : 75));
        if ((s - 1 - nbits * 100) < 25) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_frame(input int which, input logic [1:0] len, input logic [23:0] data,
                             input bit acc, input int budget, input int disturb_at,
                             output int done_at, output int busy_cnt, output int done_cnt,
                             output int wave_err, output logic [23:0] decoded);
        int   nbits, bit_start, ndec;
        logic oe, prev_oe, busy, done;
        nbits = acc ? 8 * int'(len) : 0;
        done_at = -1; busy_cnt = 0; done_cnt = 0; wave_err = 0; decoded = '0;
        bit_start = -1; ndec = 0; prev_oe = 1'b0;
        drive(which, 1'b1, len, data);
        for (int s = 1; s <= budget; s++) begin
            @(negedge clk);
            if (s == 1 || s == disturb_at + 1) drive(which, 1'b0, len, data);
            oe   = (which == 1) ? oe1 : oe2;
            busy = (which == 1) ? bus1.tx_busy : bus2.tx_busy;
            done = (which == 1) ? bus1.tx_done : bus2.tx_done;
            if (oe !== exp_oe(s, nbits, data)) wave_err++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = s;
            end
            if (oe === 1'b1 && prev_oe !== 1'b1) bit_start = s;
            if (bit_start > 0 && s == bit_start + 50) begin
                if (ndec < nbits) decoded = {decoded[22:0], ~oe};
                ndec++;
            end
            prev_oe = oe;
            if (s == disturb_at) drive(which, 1'b1, len, ~data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          d_at, b_cnt, d_cnt, w_err, pre_oe, done_seen;
        logic [23:0] dec;

        vecs[0] = '{"n64_info",  1, 2'd1, 24'h000000, 1'b1,  826, 24'h000000};
        vecs[1] = '{"n64_poll",  1, 2'd1, 24'h010000, 1'b1,  826, 24'h000001};
        vecs[2] = '{"gc_poll",   1, 2'd3, 24'h400302, 1'b1, 2426, 24'h400302};
        vecs[3] = '{"len2",      1, 2'd2, 24'hA5C300, 1'b1, 1626, 24'h00A5C3};
        vecs[4] = '{"len0",      1, 2'd0, 24'h123456, 1'b0,   -1, 24'h000000};
        vecs[5] = '{"len3_max2", 2, 2'd3, 24'hFFFF00, 1'b0,   -1, 24'h000000};
        vecs[6] = '{"len0_max2", 2, 2'd0, 24'hFFFF00, 1'b0,   -1, 24'h000000};
        vecs[7] = '{"len2_max2", 2, 2'd2, 24'h800100, 1'b1, 1626, 24'h008001};

        rst_n = 1'b0;
        drive(1, 1'b0, 2'd0, 24'h0);
        drive(2, 1'b0, 2'd0, 24'h0);
        repeat (3) @(negedge clk);
        check("rst_oe",   32'(oe1), 0);
        check("rst_busy", 32'(bus1.tx_busy), 0);
        check("rst_done", 32'(bus1.tx_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].dut, vecs[i].len, vecs[i].data, vecs[i].acc,
                      vecs[i].acc ? vecs[i].done_at + 20 : 200, -1,
                      d_at, b_cnt, d_cnt, w_err, dec);
            check({vecs[i].name, "_done_at"}, d_at, vecs[i].done_at);
            check({vecs[i].name, "_busy"}, b_cnt, vecs[i].acc ? vecs[i].done_at : 0);
            check({vecs[i].name, "_done_cnt"}, d_cnt, vecs[i].acc ? 1 : 0);
            check({vecs[i].name, "_wave_err"}, w_err, 0);
            check({vecs[i].name, "_decoded"}, 32'(dec), 32'(vecs[i].val));
            repeat (5) @(negedge clk);
        end

        // Restart attempt at cycle 300 with different data must not disturb the frame.
        run_frame(1, 2'd1, 24'h000000, 1'b1, 846, 300, d_at, b_cnt, d_cnt, w_err, dec);
        check("mid_start_done_at", d_at, 826);
        check("mid_start_wave_err", w_err, 0);
        check("mid_start_decoded", 32'(dec), 0);
        check("mid_start_busy", b_cnt, 826);
        repeat (5) @(negedge clk);

        // Start coinciding with tx_done is ignored: no second frame follows.
        run_frame(1, 2'd1, 24'h010000, 1'b1, 900, 826, d_at, b_cnt, d_cnt, w_err, dec);
        check("overlap_done_at", d_at, 826);
        check("overlap_busy", b_cnt, 826);
        check("overlap_done_cnt", d_cnt, 1);
        check("overlap_wave_err", w_err, 0);
        repeat (5) @(negedge clk);

        // Reset during the low phase of bit 5 of 0xFF.
        done_seen = 0;
        pre_oe    = 0;
        drive(1, 1'b1, 2'd1, 24'hFF0000);
        for (int s = 1; s <= 510; s++) begin
            @(negedge clk);
            if (s == 1) drive(1, 1'b0, 2'd1, 24'hFF0000);
            if (bus1.tx_done === 1'b1) done_seen++;
            if (s == 510) pre_oe = int'(oe1);
        end
        check("pre_rst_oe", pre_oe, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_oe", 32'(oe1), 0);
        check("async_rst_busy", 32'(bus1.tx_busy), 0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (bus1.tx_done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            if (bus1.tx_done === 1'b1) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        run_frame(1, 2'd1, 24'h000000, 1'b1, 846, -1, d_at, b_cnt, d_cnt, w_err, dec);
        check("post_rst_done_at", d_at, 826);
        check("post_rst_wave_err", w_err, 0);
        check("post_rst_decoded", 32'(dec), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
